ext_fifo_rx: RTL and testbench

Receive-side companion to the GEM external FIFO transmitter. It accepts the Xilinx MPSoC GEM external-FIFO receive write interface (byte writes with SOP/EOP, error and flush) and buffers each frame in a store-and-forward frame FIFO. Committed frames are presented on an 8-bit AXI4-Stream master. It also performs the `dma_rx_end_tog` / `dma_rx_status_tog` status handshake and exports the captured receive status word.

---
 rtl/ext_fifo_rx.sv | 203 ++++++++++++++++++++
 tb/tb_ext_fifo_rx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_fifo_rx.sv
// Store-and-forward receive FIFO for the GEM external-FIFO write port, with an 8-bit AXIS master
// and the dma_rx_end_tog / dma_rx_status_tog status handshake. Define EXT_FIFO_RX_DROP_BAD_EN to discard errored frames.
module ext_fifo_rx #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  gem_rx_w_data,
  input  logic        gem_rx_w_wr,
  input  logic        gem_rx_w_sop,
  input  logic        gem_rx_w_eop,
  input  logic        gem_rx_w_err,
  input  logic        gem_rx_w_flush,
  input  logic [44:0] gem_rx_w_status,
  input  logic        gem_dma_rx_end_tog,
  output logic        gem_rx_w_overflow,
  output logic        gem_dma_rx_status_tog,
  output logic [44:0] rx_status,
  output logic        rx_status_valid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

`ifdef EXT_FIFO_RX_DROP_BAD_EN
  localparam logic DROP_BAD = 1'b1;
`else
  localparam logic DROP_BAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } wr_state_e;

  // RAM entry layout: {tuser, last, data}
  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } entry_t;

  wr_state_e state_q, state_d;
  logic [AW:0] wr_cur_q, wr_cur_d;
  logic [AW:0] wr_commit_q, wr_commit_d;
  logic [AW:0] rd_q, rd_d;
  logic        acc_q, acc_d;
  logic        ovf_q, ovf_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  entry_t        ram_wdata;
  entry_t        ram_rdata;
  entry_t        mem [DEPTH];

  // A new sop always restarts at the commit point, which also aborts any frame in progress.
  logic [AW:0] frame_base;
  logic        acc_next;
  logic        base_full;
  logic        take_byte;
  logic        flush_now;

  assign frame_base = gem_rx_w_sop ? wr_commit_q : wr_cur_q;
  assign acc_next   = (gem_rx_w_sop ? 1'b0 : acc_q) | gem_rx_w_err;
  assign base_full  = (frame_base - rd_q) == DEPTH_CNT;
  assign take_byte  = gem_rx_w_wr & (gem_rx_w_sop | (state_q == S_RECV));
  assign flush_now  = gem_rx_w_flush & (state_q != S_IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    acc_d       = acc_q;
    ovf_d       = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = frame_base[AW-1:0];
    ram_wdata   = '{user: 1'b0, last: gem_rx_w_eop, data: gem_rx_w_data};

    if (flush_now) begin
      wr_cur_d = wr_commit_q;
      state_d  = S_IDLE;
    end else if (take_byte) begin
      if (base_full) begin
        wr_cur_d = wr_commit_q;
        ovf_d    = 1'b1;
        state_d  = S_DROP;
      end else begin
        ram_we         = 1'b1;
        ram_wdata.user = gem_rx_w_eop & acc_next & ~DROP_BAD;
        acc_d          = acc_next;
        if (gem_rx_w_eop) begin
          state_d = S_IDLE;
          if (DROP_BAD && acc_next) begin
            wr_cur_d = wr_commit_q;
          end else begin
            wr_cur_d    = frame_base + ONE;
            wr_commit_d = frame_base + ONE;
          end
        end else begin
          wr_cur_d = frame_base + ONE;
          state_d  = S_RECV;
        end
      end
    end else if (gem_rx_w_wr && gem_rx_w_eop && (state_q == S_DROP)) begin
      state_d = S_IDLE;
    end
  end

  // Read side: registered RAM output (stage A) feeding the AXIS output register.
  logic   a_valid_q, a_valid_d;
  logic   out_valid_q, out_valid_d;
  entry_t out_q, out_d;
  logic   rd_empty;
  logic   out_free;
  logic   a_to_out;
  logic   rd_en;

  assign rd_empty = (rd_q == wr_commit_q);
  assign out_free = ~out_valid_q | m_axis_tready;
  assign a_to_out = a_valid_q & out_free;
  assign rd_en    = ~rd_empty & (~a_valid_q | a_to_out);

  always_comb begin
    rd_d        = rd_q + (rd_en ? ONE : '0);
    a_valid_d   = rd_en | (a_valid_q & ~a_to_out);
    out_valid_d = a_to_out | (out_valid_q & ~m_axis_tready);
    out_d       = a_to_out ? ram_rdata : out_q;
  end

  // Status handshake: tog1 is the registered input, tog2 its previous value.
  logic        tog1_q, tog2_q;
  logic [44:0] status_q, status_d;
  logic        status_vld_q, status_vld_d;
  logic        status_tog_q, status_tog_d;
  logic        tog_edge;

  assign tog_edge = tog1_q ^ tog2_q;

  always_comb begin
    status_d     = tog_edge ? gem_rx_w_status : status_q;
    status_vld_d = tog_edge;
    status_tog_d = status_tog_q ^ status_vld_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      wr_cur_q     <= '0;
      wr_commit_q  <= '0;
      rd_q         <= '0;
      acc_q        <= 1'b0;
      ovf_q        <= 1'b0;
      a_valid_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      tog1_q       <= 1'b0;
      tog2_q       <= 1'b0;
      status_q     <= '0;
      status_vld_q <= 1'b0;
      status_tog_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cur_q     <= wr_cur_d;
      wr_commit_q  <= wr_commit_d;
      rd_q         <= rd_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      a_valid_q    <= a_valid_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      tog1_q       <= gem_dma_rx_end_tog;
      tog2_q       <= tog1_q;
      status_q     <= status_d;
      status_vld_q <= status_vld_d;
      status_tog_q <= status_tog_d;
    end
  end

  // NOTE: the RAM and its read register have no reset; pointers and valid flags gate every use.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (rd_en)  ram_rdata <= mem[rd_q[AW-1:0]];
  end

  assign gem_rx_w_overflow     = ovf_q;
  assign gem_dma_rx_status_tog = status_tog_q;
  assign rx_status             = status_q;
  assign rx_status_valid       = status_vld_q;
  assign m_axis_tvalid         = out_valid_q;
  assign m_axis_tdata          = out_q.data;
  assign m_axis_tlast          = out_q.last;
  assign m_axis_tuser          = out_q.user;

endmodule

// File: tb/tb_ext_fifo_rx.sv
// Self-checking bench for ext_fifo_rx: frame-level queue model plus directed scenarios.
module tb_ext_fifo_rx;

  localparam int DEPTH = 64;

`ifdef EXT_FIFO_RX_DROP_BAD_EN
  localparam bit DROP_BAD = 1'b1;
`else
  localparam bit DROP_BAD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  gem_rx_w_data = '0;
  logic        gem_rx_w_wr = 1'b0;
  logic        gem_rx_w_sop = 1'b0;
  logic        gem_rx_w_eop = 1'b0;
  logic        gem_rx_w_err = 1'b0;
  logic        gem_rx_w_flush = 1'b0;
  logic [44:0] gem_rx_w_status = '0;
  logic        gem_dma_rx_end_tog = 1'b0;
  logic        gem_rx_w_overflow;
  logic        gem_dma_rx_status_tog;
  logic [44:0] rx_status;
  logic        rx_status_valid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  always #5 clk = ~clk;

  ext_fifo_rx #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .gem_rx_w_data         (gem_rx_w_data),
    .gem_rx_w_wr           (gem_rx_w_wr),
    .gem_rx_w_sop          (gem_rx_w_sop),
    .gem_rx_w_eop          (gem_rx_w_eop),
    .gem_rx_w_err          (gem_rx_w_err),
    .gem_rx_w_flush        (gem_rx_w_flush),
    .gem_rx_w_status       (gem_rx_w_status),
    .gem_dma_rx_end_tog    (gem_dma_rx_end_tog),
    .gem_rx_w_overflow     (gem_rx_w_overflow),
    .gem_dma_rx_status_tog (gem_dma_rx_status_tog),
    .rx_status             (rx_status),
    .rx_status_valid       (rx_status_valid),
    .m_axis_tdata          (m_axis_tdata),
    .m_axis_tvalid         (m_axis_tvalid),
    .m_axis_tready         (m_axis_tready),
    .m_axis_tlast          (m_axis_tlast),
    .m_axis_tuser          (m_axis_tuser)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: bytes of the open frame, error accumulator, and the expected beat stream.
  beat_t      exp_q[$];
  logic [7:0] cur[$];
  bit         in_frame = 0;
  bit         dropping = 0;
  bit         acc = 0;
  bit         ovf_pending = 0;
  bit         ovf_now = 0;
  bit         toggle_rdy = 0;

  int         beats_seen = 0;
  int         ovf_seen = 0;
  logic [7:0] last_data = '0;
  logic       last_user = 1'b0;

  task automatic model_commit();
    if (!(DROP_BAD && acc)) begin
      foreach (cur[i]) begin
        beat_t b;
        b.d = cur[i];
        b.l = (i == cur.size() - 1);
        b.u = (i == cur.size() - 1) ? acc : 1'b0;
        exp_q.push_back(b);
      end
    end
    cur.delete();
    in_frame = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    ovf_now     = ovf_pending;
    ovf_pending = 0;
    if (toggle_rdy) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic gem_wr(input logic [7:0] d, input logic sop, input logic eop, input logic err);
    gem_rx_w_data = d;
    gem_rx_w_wr   = 1'b1;
    gem_rx_w_sop  = sop;
    gem_rx_w_eop  = eop;
    gem_rx_w_err  = err;
    if (sop) begin
      cur.delete();
      acc      = 0;
      in_frame = 1;
      dropping = 0;
    end
    if (in_frame) begin
      if (cur.size() == DEPTH) begin
        ovf_pending = 1;
        in_frame    = 0;
        dropping    = 1;
        cur.delete();
      end else begin
        cur.push_back(d);
        acc = acc | err;
        if (eop) model_commit();
      end
    end else if (dropping && eop) begin
      dropping = 0;
    end
    cycle();
    gem_rx_w_wr  = 1'b0;
    gem_rx_w_sop = 1'b0;
    gem_rx_w_eop = 1'b0;
    gem_rx_w_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] first, input int len, input logic err_eop);
    for (int i = 0; i < len; i++)
      gem_wr(first + 8'(i), i == 0, i == len - 1, err_eop && (i == len - 1));
  endtask

  task automatic flush_now();
    gem_rx_w_flush = 1'b1;
    cur.delete();
    in_frame = 0;
    dropping = 0;
    cycle();
    gem_rx_w_flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_axis_tready = 1'b1;
    repeat (4) cycle();
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Compare process: overflow pulse, AXIS hold rules and beat content on every cycle.
  bit    prev_stall = 0;
  beat_t prev_beat;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 0;
    end else begin
      check("overflow", gem_rx_w_overflow, ovf_now);
      if (gem_rx_w_overflow) ovf_seen++;
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", m_axis_tvalid, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e.d);
          check("beat_last", m_axis_tlast, e.l);
          if (e.l) check("beat_user", m_axis_tuser, e.u);
          beats_seen++;
          if (m_axis_tlast) begin
            last_data = m_axis_tdata;
            last_user = m_axis_tuser;
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int o0;

    // Reset state
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_outputs", {m_axis_tdata, m_axis_tlast, m_axis_tuser, gem_rx_w_overflow}, 0);
    check("rst_status", {rx_status, rx_status_valid, gem_dma_rx_status_tog}, 0);
    rstn = 1'b1;
    cycle();

    // 64-byte good frame, ready high, latency of 2 cycles after eop
    m_axis_tready = 1'b1;
    b0 = beats_seen;
    for (int i = 0; i < 64; i++) gem_wr(8'(i), i == 0, i == 63, 1'b0);
    check("lat_k0", m_axis_tvalid, 0);
    cycle();
    check("lat_k1", m_axis_tvalid, 0);
    cycle();
    check("lat_k2", m_axis_tvalid, 1);
    check("lat_first_data", m_axis_tdata, 8'h00);
    drain();
    check("t1_beats", beats_seen - b0, 64);
    check("t1_last_data", last_data, 8'h3F);
    check("t1_last_user", last_user, 0);

    // 20-byte frame with err on eop, then a good frame
    b0 = beats_seen;
    send_frame(8'h80, 20, 1'b1);
    drain();
    check("t2_err_beats", beats_seen - b0, DROP_BAD ? 0 : 20);
    check("t2_err_last", last_data, DROP_BAD ? 8'h3F : 8'h93);
    check("t2_err_user", last_user, DROP_BAD ? 0 : 1);
    b0 = beats_seen;
    send_frame(8'hA0, 4, 1'b0);
    drain();
    check("t2_good_beats", beats_seen - b0, 4);
    check("t2_good_user", last_user, 0);

    // Overflow: 100-byte frame into a 64-byte buffer with ready low
    m_axis_tready = 1'b0;
    b0 = beats_seen;
    o0 = ovf_seen;
    for (int i = 0; i < 100; i++) begin
      gem_wr(8'(i), i == 0, i == 99, 1'b0);
      if (i == 63) check("ovf_not_yet", gem_rx_w_overflow, 0);
      if (i == 64) check("ovf_pulse", gem_rx_w_overflow, 1);
    end
    repeat (4) cycle();
    check("t3_ovf_count", ovf_seen - o0, 1);
    check("t3_no_output", m_axis_tvalid, 0);
    send_frame(8'hC0, 10, 1'b0);
    repeat (4) cycle();
    check("t3_held_valid", m_axis_tvalid, 1);
    check("t3_held_data", m_axis_tdata, 8'hC0);
    drain();
    check("t3_beats", beats_seen - b0, 10);
    check("t3_last_data", last_data, 8'hC9);

    // Back-to-back 1-byte frames with ready toggling
    b0 = beats_seen;
    toggle_rdy = 1;
    gem_wr(8'h11, 1'b1, 1'b1, 1'b0);
    gem_wr(8'h22, 1'b1, 1'b1, 1'b0);
    repeat (8) cycle();
    toggle_rdy = 0;
    drain();
    check("t4_beats", beats_seen - b0, 2);
    check("t4_last_data", last_data, 8'h22);

    // Flush after 5 bytes, then an 8-byte frame
    b0 = beats_seen;
    for (int i = 0; i < 5; i++) gem_wr(8'h50 + 8'(i), i == 0, 1'b0, 1'b0);
    flush_now();
    send_frame(8'h60, 8, 1'b0);
    drain();
    check("t5_beats", beats_seen - b0, 8);
    check("t5_last_data", last_data, 8'h67);

    // Reset with a committed frame stored and another in progress
    m_axis_tready = 1'b0;
    send_frame(8'h70, 3, 1'b0);
    gem_wr(8'h78, 1'b1, 1'b0, 1'b0);
    gem_wr(8'h79, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    rstn = 1'b0;
    #1;
    check("t5_rst_tvalid", m_axis_tvalid, 0);
    exp_q.delete();
    cur.delete();
    in_frame = 0;
    dropping = 0;
    repeat (2) cycle();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_post_rst_empty", m_axis_tvalid, 0);
    end
    b0 = beats_seen;
    m_axis_tready = 1'b1;
    send_frame(8'h90, 3, 1'b0);
    drain();
    check("t5_post_rst_beats", beats_seen - b0, 3);
    check("t5_post_rst_last", last_data, 8'h92);

    // Status handshake
    gem_rx_w_status = 45'h1_2345_6789_AB;
    cycle();
    gem_dma_rx_end_tog = 1'b1;
    cycle();
    check("st1_c1_valid", rx_status_valid, 0);
    check("st1_c1_tog", gem_dma_rx_status_tog, 0);
    cycle();
    check("st1_c2_valid", rx_status_valid, 1);
    check("st1_c2_status", rx_status, 45'h1_2345_6789_AB);
    check("st1_c2_tog", gem_dma_rx_status_tog, 0);
    cycle();
    check("st1_c3_valid", rx_status_valid, 0);
    check("st1_c3_tog", gem_dma_rx_status_tog, 1);
    cycle();
    check("st1_c4_valid", rx_status_valid, 0);

    gem_rx_w_status = 45'h0_0F0F_1234_56;
    cycle();
    gem_dma_rx_end_tog = 1'b0;
    repeat (2) cycle();
    check("st2_c2_valid", rx_status_valid, 1);
    check("st2_c2_status", rx_status, 45'h0_0F0F_1234_56);
    cycle();
    check("st2_c3_tog", gem_dma_rx_status_tog, 0);
    check("st2_c3_valid", rx_status_valid, 0);

    repeat (3) cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
